addmul_arbiter: RTL and testbench
=================================

# addmul_arbiter

Round-robin arbiter and sequencer that shares one pipelined (A+B)*C datapath between two requesters. It accepts operand triples over valid/ready, drives the datapath operands and its clock enable, and tracks a tag per in-flight operation. It routes each product back to the requester that issued it. It sits between the two client blocks and the `addition` datapath instance, and is the only driver of that instance's `ce`.

## Interface
- `DATA_W`, 10, operand width (signed two's complement).
- `RES_W`, 21, result width, matching the datapath product.
- `PIPE_LAT`, 4, datapath latency in enabled clock cycles, from operand capture to valid `Y`; legal range 1..16.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operand triple.
- `req0_ready` / `req1_ready`  out  1  triple accepted this cycle when valid && ready.
- `req0_a`, `req0_b`, `req0_c` / `req1_a`, `req1_b`, `req1_c`  in  DATA_W each  operands.
- `dp_ce`  out  1  datapath clock enable.
- `dp_a`, `dp_b`, `dp_c`  out  DATA_W each  muxed operands to the datapath.
- `dp_y`  in  RES_W  datapath result.
- `res0_valid` / `res1_valid`  out  1  result for that requester on `resN_y`.
- `res0_ready` / `res1_ready`  in  1  requester takes the result.
- `res0_y` / `res1_y`  out  RES_W  result, equal to `dp_y`.

## Operation
- The tag pipeline has `PIPE_LAT` stages, each holding {valid, id}. It shifts only when `dp_ce`=1. Stage 0 loads {accepted, grant_id}.
- Head is the last stage. `resN_valid` = head.valid && head.id==N. Both `resN_y` carry `dp_y` unmodified; consumers qualify them with `resN_valid`.
- Stall condition: head.valid && !res_ready[head.id]. While stalled, `dp_ce`=0 and the whole datapath and tag pipeline freeze. Otherwise `dp_ce`=1.
- The arbiter keeps a priority state with two states: PRIO0 and PRIO1.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester named by the priority state is granted.
  - On any accepted transfer, priority moves to the other requester.
  - No transfer: priority holds.
- `reqN_ready` = `dp_ce` && grant==N && !`rst`. At most one ready is high per cycle.
- `dp_a`, `dp_b`, `dp_c` carry the granted requester's operands. With no grant they carry requester 0's operands, and stage 0 loads valid=0 (a bubble).
- No arithmetic is done here. Signedness and widths pass through; result = (A+B)*C, sign-extended to `RES_W` by the datapath.

## Timing
- Reset values:
  - all tag stages invalid
  - priority = PRIO0
  - `resN_valid`=0
  - `reqN_ready`=0 while `rst` is high
  - `dp_ce`=1
- Latency: a transfer accepted at edge k produces `resN_valid`=1 exactly `PIPE_LAT` enabled edges later. With no stalls that is `PIPE_LAT` cycles.
- Throughput: one operation per cycle without stalls. Back-to-back acceptance from one requester is allowed when the other requester is idle.
- A result is consumed on the edge where `resN_valid` && `resN_ready` are both high. The head advances on that edge.
- Simultaneous head consume and new accept in the same cycle is legal.
- A stall caused by requester 0 also blocks requester 1's issue and results (head-of-line blocking is intended).
- Reset mid-operation: all in-flight tags are dropped immediately (asynchronously) and their results are never presented. Pending request data is not accepted.

## Configuration
- `ADDMUL_ARB_STATS_EN` defined adds three 16-bit saturating counters, each cleared by `rst`:
  - `stat_issue0`: transfers accepted from requester 0
  - `stat_issue1`: transfers accepted from requester 1
  - `stat_stall`: cycles with `dp_ce`=0
  - exposed as outputs with those names.
- Not defined: the counters and their ports are absent. Functional behaviour is identical in both cases.

## Structure
- Package `addmul_pkg`:
  - `DATA_W`, `RES_W` defaults
  - `req_id_t` (1 bit)
  - `tag_t` struct {valid, id}
  - priority-state enum {PRIO0, PRIO1}
- Sub-module `addmul_tag_pipe`: parameterised `PIPE_LAT`-deep shift register of `tag_t` with enable and async reset, exposing the head tag.

## Test plan
- Single op: req0 sends (3, 4, 5), result always ready. Expect `res0_valid` 4 cycles after accept with `res0_y`=35 and `res1_valid` staying 0.
- Signed: req1 sends (-2, 1, 3). Expect `res1_y`=21'h1FFFFD (-3).
- Contention: both valid every cycle for 6 cycles. Expect grants alternate 0,1,0,1,0,1 starting with 0 after reset, and results return in the same order to the matching ports.
- Backpressure: `res0_ready`=0 for 3 cycles while the head is req0's result. Expect `dp_ce`=0 for 3 cycles, both `reqN_ready`=0, the result held stable, then delivery and resumption with no loss or duplication.
- Reset mid-flight: assert `rst` with 3 ops in flight. Expect no `resN_valid` afterwards, priority back to PRIO0, and correct results for new ops issued after reset.
- With `ADDMUL_ARB_STATS_EN` defined: 5 req0 ops, 2 req1 ops and 3 stall cycles give counters 5/2/3. Counters saturate at 16'hFFFF.

Source files
------------

// File: rtl/addmul_pkg.sv
// addmul_pkg: shared types and default widths for the (A+B)*C arbiter slice.
package addmul_pkg;

  localparam int DATA_W = 10;
  localparam int RES_W  = 21;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  typedef enum logic {
    PRIO0 = 1'b0,
    PRIO1 = 1'b1
  } prio_t;

  // After a transfer from one requester, the other one gets priority.
  function automatic prio_t prio_after(req_id_t id);
    return (id == 1'b0) ? PRIO1 : PRIO0;
  endfunction

endpackage

// File: rtl/addmul_tag_pipe.sv
// addmul_tag_pipe: PIPE_LAT-deep shift register of {valid, id} tags that
// tracks which requester owns each operation inside the datapath.
module addmul_tag_pipe
  import addmul_pkg::*;
#(
  parameter int PIPE_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  tag_t tag_in,
  output tag_t head
);

  tag_t stages [PIPE_LAT];

  // Shift tags in lockstep with the datapath enable; reset drops every tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        stages[i] <= '0;
      end
    end else if (en) begin
      stages[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign head = stages[PIPE_LAT-1];

endmodule

// File: rtl/addmul_arbiter.sv
// addmul_arbiter: round-robin arbiter/sequencer sharing one pipelined
// (A+B)*C datapath between two requesters. Owns the datapath clock enable
// and steers each product back to the requester that issued it.
// Optional build macro ADDMUL_ARB_STATS_EN adds saturating issue/stall
// counters (stat_issue0, stat_issue1, stat_stall).
module addmul_arbiter #(
  parameter int DATA_W   = addmul_pkg::DATA_W,
  parameter int RES_W    = addmul_pkg::RES_W,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req0_c,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [DATA_W-1:0] req1_c,
  output logic              dp_ce,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b,
  output logic [DATA_W-1:0] dp_c,
  input  logic [RES_W-1:0]  dp_y,
  output logic              res0_valid,
  input  logic              res0_ready,
  output logic [RES_W-1:0]  res0_y,
  output logic              res1_valid,
  input  logic              res1_ready,
  output logic [RES_W-1:0]  res1_y
`ifdef ADDMUL_ARB_STATS_EN
  ,
  output logic [15:0]       stat_issue0,
  output logic [15:0]       stat_issue1,
  output logic [15:0]       stat_stall
`endif
);

  import addmul_pkg::*;

  tag_t    head;
  tag_t    stage0_in;
  prio_t   prio;
  logic    grant_valid;
  req_id_t grant_id;
  logic    accepted;
  logic    stall;

  // Head-of-line stall: a finished result whose owner is not ready freezes everything.
  always_comb begin
    stall = head.valid && ((head.id == 1'b1) ? !res1_ready : !res0_ready);
  end

  assign dp_ce = !stall;

  // Round-robin grant; the priority state only matters when both are asking.
  always_comb begin
    grant_valid = req0_valid || req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = (prio == PRIO1);
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Handshake and operand steering; no grant leaves requester 0 on the bus.
  always_comb begin
    accepted   = dp_ce && grant_valid && !rst;
    req0_ready = accepted && (grant_id == 1'b0);
    req1_ready = accepted && (grant_id == 1'b1);
    dp_a       = req0_a;
    dp_b       = req0_b;
    dp_c       = req0_c;
    if (grant_valid && (grant_id == 1'b1)) begin
      dp_a = req1_a;
      dp_b = req1_b;
      dp_c = req1_c;
    end
    stage0_in.valid = accepted;
    stage0_in.id    = grant_id;
  end

  // Priority state: flips to the other requester on every accepted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= PRIO0;
    end else if (accepted) begin
      prio <= prio_after(grant_id);
    end
  end

  addmul_tag_pipe #(
    .PIPE_LAT (PIPE_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rst    (rst),
    .en     (dp_ce),
    .tag_in (stage0_in),
    .head   (head)
  );

  // Result routing: both ports see dp_y, only the owner gets valid.
  always_comb begin
    res0_valid = head.valid && (head.id == 1'b0);
    res1_valid = head.valid && (head.id == 1'b1);
    res0_y     = dp_y;
    res1_y     = dp_y;
  end

`ifdef ADDMUL_ARB_STATS_EN
  // Saturating activity counters for issue per requester and stall cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issue0 <= '0;
      stat_issue1 <= '0;
      stat_stall  <= '0;
    end else begin
      if (req0_ready && req0_valid && (stat_issue0 != 16'hFFFF)) begin
        stat_issue0 <= stat_issue0 + 16'd1;
      end
      if (req1_ready && req1_valid && (stat_issue1 != 16'hFFFF)) begin
        stat_issue1 <= stat_issue1 + 16'd1;
      end
      if (!dp_ce && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addmul_arbiter.sv
// tb_addmul_arbiter: directed self-checking bench for addmul_arbiter with a
// behavioural 4-stage (A+B)*C datapath attached to the dp_* port.
module tb_addmul_arbiter;

  localparam int DW  = 10;
  localparam int RW  = 21;
  localparam int LAT = 4;

  logic          clk;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic          dp_ce;
  logic [DW-1:0] dp_a, dp_b, dp_c;
  logic [RW-1:0] dp_y;
  logic          res0_valid, res0_ready, res1_valid, res1_ready;
  logic [RW-1:0] res0_y, res1_y;
`ifdef ADDMUL_ARB_STATS_EN
  logic [15:0]   stat_issue0, stat_issue1, stat_stall;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [RW-1:0] cont_exp [6] = '{21'd2, 21'h1FFFE5, 21'd6, 21'h1FFFEB, 21'd10, 21'h1FFFF1};

  addmul_arbiter #(
    .DATA_W   (DW),
    .RES_W    (RW),
    .PIPE_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_c     (req0_c),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_c     (req1_c),
    .dp_ce      (dp_ce),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_c       (dp_c),
    .dp_y       (dp_y),
    .res0_valid (res0_valid),
    .res0_ready (res0_ready),
    .res0_y     (res0_y),
    .res1_valid (res1_valid),
    .res1_ready (res1_ready),
    .res1_y     (res1_y)
`ifdef ADDMUL_ARB_STATS_EN
    ,
    .stat_issue0 (stat_issue0),
    .stat_issue1 (stat_issue1),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: operands captured on an enabled edge, Y after LAT enabled edges.
  function automatic logic [RW-1:0] addmul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c);
    int s;
    int p;
    s = int'($signed(a)) + int'($signed(b));
    p = s * int'($signed(c));
    return p[RW-1:0];
  endfunction

  logic [RW-1:0] dpm [LAT];
  always @(posedge clk) begin
    if (dp_ce) begin
      dpm[0] <= addmul(dp_a, dp_b, dp_c);
      for (int i = 1; i < LAT; i++) dpm[i] <= dpm[i-1];
    end
  end
  assign dp_y = dpm[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic v, input int a, input int b, input int c);
    req0_valid = v;
    req0_a = a[DW-1:0];
    req0_b = b[DW-1:0];
    req0_c = c[DW-1:0];
  endtask

  task automatic drv1(input logic v, input int a, input int b, input int c);
    req1_valid = v;
    req1_a = a[DW-1:0];
    req1_b = b[DW-1:0];
    req1_c = c[DW-1:0];
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // One isolated operation from requester id; result expected LAT cycles after accept.
  task automatic single_op(input bit id, input int a, input int b, input int c,
                           input logic [RW-1:0] exp, input string tag);
    @(negedge clk);
    if (id) drv1(1'b1, a, b, c); else drv0(1'b1, a, b, c);
    #1;
    chk({tag, "_ready"}, id ? req1_ready : req0_ready, 1);
    chk({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      idle();
      #1;
      if (i < LAT) begin
        chk({tag, "_early_valid"}, id ? res1_valid : res0_valid, 0);
      end else begin
        chk({tag, "_valid"}, id ? res1_valid : res0_valid, 1);
        chk({tag, "_y"}, id ? res1_y : res0_y, {11'd0, exp});
      end
      chk({tag, "_wrong_port"}, id ? res0_valid : res1_valid, 0);
    end
    @(negedge clk);
    #1;
    chk({tag, "_consumed"}, id ? res1_valid : res0_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    drv0(1'b1, 0, 0, 0);
    drv1(1'b1, 0, 0, 0);
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_dp_ce", dp_ce, 1);
    chk("rst_res0_valid", res0_valid, 0);
    chk("rst_res1_valid", res1_valid, 0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Single unsigned op and a signed op
    single_op(1'b0, 3, 4, 5, 21'd35, "single");
    single_op(1'b1, -2, 1, 3, 21'h1FFFFD, "signed");

    // Contention: both valid for 6 cycles, grants alternate starting at 0
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t < 6) begin
        drv0(1'b1, t, 1, 2);
        drv1(1'b1, t, -10, 3);
      end else begin
        idle();
      end
      #1;
      if (t < 6) begin
        chk("cont_ready0", req0_ready, (t % 2 == 0));
        chk("cont_ready1", req1_ready, (t % 2 == 1));
      end
      if (t >= 4) begin
        chk("cont_res0_valid", res0_valid, (t % 2 == 0));
        chk("cont_res1_valid", res1_valid, (t % 2 == 1));
        chk("cont_y", (t % 2 == 0) ? res0_y : res1_y, {11'd0, cont_exp[t-4]});
      end
    end
    @(negedge clk);
    #1;
    chk("cont_drained0", res0_valid, 0);
    chk("cont_drained1", res1_valid, 0);

    // Backpressure: req0 result held at head for 3 cycles
    @(negedge clk);
    drv0(1'b1, 5, 5, 2);
    #1;
    chk("bp_issue_a", req0_ready, 1);
    @(negedge clk);
    drv0(1'b0, 0, 0, 0);
    drv1(1'b1, 1, 1, 1);
    #1;
    chk("bp_issue_b", req1_ready, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      res0_ready = 1'b0;
      drv0(1'b1, 2, 2, 2);
      drv1(1'b1, 3, 0, 4);
      #1;
      chk("bp_ce", dp_ce, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_res0_valid", res0_valid, 1);
      chk("bp_res0_y", res0_y, 20);
      chk("bp_res1_valid", res1_valid, 0);
    end
    @(negedge clk);
    res0_ready = 1'b1;
    #1;
    chk("bp_release_ce", dp_ce, 1);
    chk("bp_release_y", res0_y, 20);
    chk("bp_release_ready0", req0_ready, 1);
    chk("bp_release_ready1", req1_ready, 0);
    @(negedge clk);
    drv0(1'b0, 0, 0, 0);
    #1;
    chk("bp_no_dup", res0_valid, 0);
    chk("bp_b_valid", res1_valid, 1);
    chk("bp_b_y", res1_y, 2);
    chk("bp_d_ready1", req1_ready, 1);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      idle();
      #1;
      chk("bp_tail_res0", res0_valid, (t == 2));
      chk("bp_tail_res1", res1_valid, (t == 3));
      if (t == 2) chk("bp_c_y", res0_y, 8);
      if (t == 3) chk("bp_d_y", res1_y, 12);
    end

    // Reset with three ops in flight (priority left at PRIO1)
    @(negedge clk);
    drv0(1'b1, 1, 1, 1);
    #1;
    chk("rf_issue0", req0_ready, 1);
    @(negedge clk);
    drv0(1'b0, 0, 0, 0);
    drv1(1'b1, 1, 1, 1);
    #1;
    chk("rf_issue1", req1_ready, 1);
    @(negedge clk);
    drv1(1'b0, 0, 0, 0);
    drv0(1'b1, 1, 1, 1);
    #1;
    chk("rf_issue2", req0_ready, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    chk("rf_head_before", res0_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rf_async_drop0", res0_valid, 0);
    chk("rf_async_drop1", res1_valid, 0);
    chk("rf_ce", dp_ce, 1);
    drv0(1'b1, 4, -1, -7);
    drv1(1'b1, 10, 10, 10);
    #1;
    chk("rf_ready0_in_rst", req0_ready, 0);
    chk("rf_ready1_in_rst", req1_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rf_prio_ready0", req0_ready, 1);
    chk("rf_prio_ready1", req1_ready, 0);
    @(negedge clk);
    drv0(1'b0, 0, 0, 0);
    #1;
    chk("rf_second_ready1", req1_ready, 1);
    for (int t = 2; t < 8; t++) begin
      @(negedge clk);
      idle();
      #1;
      chk("rf_post_res0", res0_valid, (t == 4));
      chk("rf_post_res1", res1_valid, (t == 5));
      if (t == 4) chk("rf_post_y0", res0_y, 21'h1FFFEB);
      if (t == 5) chk("rf_post_y1", res1_y, 200);
    end

`ifdef ADDMUL_ARB_STATS_EN
    // Counters: 5 req0 issues, 2 req1 issues, 3 stall cycles after a reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      drv0(t < 5, t, 1, 1);
      drv1((t >= 5) && (t < 7), t, 2, 1);
      res1_ready = !((t >= 9) && (t < 12));
      #1;
      if (t == 10) chk("stat_stall_ce", dp_ce, 0);
    end
    #1;
    chk("stat_issue0", stat_issue0, 5);
    chk("stat_issue1", stat_issue1, 2);
    chk("stat_stall", stat_stall, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
